// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the data-memory load/store unit: widths, size and state encodings.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_lsu_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int DMEM_ADDRW = 10;
  localparam int BYTE_ADDRW = DMEM_ADDRW + 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RDATA = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // A request is rejected for the reserved size or for a half/word access off its natural alignment.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    err = 1'b1;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = lane[0];
      SIZE_WORD: err = (lane != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// Latency: none (wires only).
// Backpressure: req_ready gates acceptance of req_valid; the memory side never stalls.
interface dmem_lsu_if
  import dmem_lsu_pkg::*;
();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [BYTE_ADDRW-1:0] req_addr;
  logic [WORD_SIZE-1:0]  req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [WORD_SIZE-1:0]  resp_rdata;
  logic                  mem_wen;
  logic [DMEM_ADDRW-1:0] mem_waddr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [DMEM_ADDRW-1:0] mem_raddr;
  logic [WORD_SIZE-1:0]  mem_rdata;

  // The unit's view: serves CPU requests and drives the memory ports.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_wen, mem_waddr, mem_wdata, mem_raddr
  );

  // The environment's view: CPU pipeline plus the memory macro.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_wen, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           lane,
  input  logic                 sign_ext,
  input  logic [WORD_SIZE-1:0] rdata,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] merge_data
);
  logic [4:0]           sh;
  logic [WORD_SIZE-1:0] shifted;

  assign sh      = {lane, 3'b000};
  assign shifted = rdata >> sh;

  // Right-align the addressed lane(s) and extend to a full word.
  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_BYTE: load_data = sign_ext ? {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]}
                                      : {{(WORD_SIZE-8){1'b0}}, shifted[7:0]};
      SIZE_HALF: load_data = sign_ext ? {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]}
                                      : {{(WORD_SIZE-16){1'b0}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with the low bits of the store data.
  always_comb begin
    merge_data = wdata;
    case (size)
      SIZE_BYTE: merge_data = (rdata & ~(32'h0000_00FF << sh))
                            | ({{(WORD_SIZE-8){1'b0}}, wdata[7:0]} << sh);
      SIZE_HALF: merge_data = (rdata & ~(32'h0000_FFFF << sh))
                            | ({{(WORD_SIZE-16){1'b0}}, wdata[15:0]} << sh);
      default:   merge_data = wdata;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: sole initiator of the sync-read data memory; sub-word stores are read-modify-write.
// Latency accept->resp_valid: error 1, word store 2, load 3, sub-word store 4 cycles.
// Backpressure: req_ready high only in IDLE outside reset; one request in flight, no overlap.
module dmem_lsu
  import dmem_lsu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);
  state_e                state_q, state_d;
  logic                  accept;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [BYTE_ADDRW-1:0] addr_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic                  err_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [WORD_SIZE-1:0]  merge_q;
  logic [DMEM_ADDRW-1:0] idx_q;
  logic [WORD_SIZE-1:0]  load_data;
  logic [WORD_SIZE-1:0]  merge_data;

  assign idx_q = addr_q[BYTE_ADDRW-1:2];

  dmem_lane_align u_align (
    .size       (size_q),
    .lane       (addr_q[1:0]),
    .sign_ext   (signed_q),
    .rdata      (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request latch at accept, plus load result / merged word captured while read data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        err_q    <= req_is_err(bus.req_size, bus.req_addr[1:0]);
        rdata_q  <= '0;
      end
      if (state_q == ST_RDATA) begin
        rdata_q <= we_q ? '0 : load_data;
        merge_q <= merge_data;
      end
    end
  end

  // Next-state and state-decoded outputs; memory ports read as zero outside their active states.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_wen    = 1'b0;
    bus.mem_waddr  = '0;
    bus.mem_wdata  = '0;
    bus.mem_raddr  = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = !rst;
        accept        = bus.req_valid && !rst;
        if (accept) begin
          if (req_is_err(bus.req_size, bus.req_addr[1:0]))  state_d = ST_RESP;
          else if (bus.req_we && bus.req_size == SIZE_WORD) state_d = ST_WR;
          else                                              state_d = ST_RD;
        end
      end
      ST_RD: begin
        bus.mem_raddr = idx_q;
        state_d       = ST_RDATA;
      end
      ST_RDATA: begin
        bus.mem_raddr = idx_q;
        state_d       = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        bus.mem_raddr = idx_q;
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = (size_q == SIZE_WORD) ? wdata_q : merge_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        bus.mem_raddr  = idx_q;
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that acts as the sole initiator of the single-port-write, synchronous-read data memory (1-cycle registered read latency). It accepts byte, half-word and word load/store requests from the CPU pipeline over a valid/ready handshake, using byte addresses. It performs sub-word stores as read-modify-write, and returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
WORD_SIZE, 32, data word width. Fixed at 32, giving 4 byte lanes and 2 offset bits.
DMEM_ADDRW, 10, word-address width of the data memory.

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE and not in reset
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
req_addr  in  DMEM_ADDRW+2  byte address
req_wdata  in  WORD_SIZE  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  misaligned or reserved size; qualified by resp_valid
resp_rdata  out  WORD_SIZE  extended load data; 0 for stores and errors
mem_wen  out  1  memory write enable
mem_waddr  out  DMEM_ADDRW  memory write word address
mem_wdata  out  WORD_SIZE  memory write data
mem_raddr  out  DMEM_ADDRW  memory read word address
mem_rdata  in  WORD_SIZE  memory read data, valid one cycle after mem_raddr is sampled

Behaviour:
- Accept: a request is accepted when req_valid && req_ready at a posedge. The unit latches we, size, signed, addr and wdata at that edge.
- Word index = addr[DMEM_ADDRW+1:2]. Lane = addr[1:0]. Byte order is little-endian; lane 0 = bits 7:0.
- Error: the request is an error if size==11, half with addr[0]==1, or word with addr[1:0]!=0. An error makes no memory access and goes IDLE->RESP with resp_err=1.
- State machine: IDLE, RD, RDATA, WR, RESP.
  - IDLE: accept. Word store -> WR. Load or sub-word store -> RD. Error -> RESP.
  - RD: mem_raddr = latched word index. The memory samples it at the end of this cycle. -> RDATA.
  - RDATA: mem_rdata is valid. Load: extract the lane, extend, register into resp_rdata, -> RESP. Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane(s) of mem_rdata, register the merged word, -> WR.
  - WR: mem_wen=1 for exactly this cycle, mem_waddr = word index, mem_wdata = merged word (word store: wdata as is). -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_err as decided. -> IDLE.
- Latency, in cycles from the accept edge to resp_valid high:
  - error 1
  - word store 2
  - load 3
  - sub-word store 4
- Throughput: req_ready is low in every state except IDLE, so there is no overlap between requests. A request held valid during RESP is accepted in the following IDLE cycle.
- mem_wen is 0 outside WR. mem_waddr and mem_wdata are 0 outside WR. mem_raddr holds the latched word index in all non-IDLE states and is 0 in IDLE.
- The unit is the only writer to the memory, so the RMW read-then-write window needs no interlock.
- Reset: while rst is sampled high, state=IDLE and req_ready=0. All registered outputs reset to 0: resp_valid, resp_err, resp_rdata, mem_wen, mem_waddr, mem_wdata, mem_raddr.
- Reset mid-operation: the in-flight request is dropped. No mem_wen and no resp_valid follow for it.

Decomposition:
- Shared constants file (the existing define.vh) gains: WORD_SIZE, DMEM_ADDRW, SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, and the state encodings.
- One natural combinational sub-module, dmem_lane_align, containing the lane extract + sign/zero-extend function and the lane-merge function. The FSM stays in dmem_lsu.

Test Plan:
1. Word store: addr 0x010, data 0xDEADBEEF. Expect mem_wen pulse at cycle 1 with waddr=4; resp_valid at cycle 2, err=0. Then a word load of 0x010 returns 0xDEADBEEF at cycle 3.
2. Byte store: addr 0x012, data 0x000000A5, over the word in scenario 1. Expect RD then WR, with mem_wdata=0xDEA5BEEF; resp_valid at cycle 4.
3. Loads from word 0xDEA5BEEF:
   - signed byte at 0x012 -> 0xFFFFFFA5
   - unsigned byte at 0x012 -> 0x000000A5
   - signed half at 0x010 -> 0xFFFFBEEF
   - unsigned half at 0x012 -> 0x0000DEA5
4. Errors:
   - half load at 0x011 -> resp_valid at cycle 1, err=1, rdata=0, no mem_wen
   - size=11 -> same response
5. Reset during a sub-word store: assert rst in the RDATA cycle. Expect no mem_wen and no resp_valid; memory unchanged; req_ready=1 the cycle after rst deasserts.
6. Back-to-back: req_valid held high across 3 word stores. Each is accepted only in IDLE, each gives exactly one mem_wen and one resp_valid, and addresses appear in order.
